// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, widths and counter helper for the branch target buffer
package bp_pkg;

  localparam int BP_PC_W    = 64;
  localparam int BP_ENTRIES = 16;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_PC_W - BP_IDX_W - 2;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_PC_W-1:0]  target;
    cnt_t                cnt;
  } bp_entry_t;

  function automatic cnt_t sat_next(input cnt_t c, input logic taken);
    if (taken) return (c == ST) ? ST : cnt_t'(c + 2'd1);
    return (c == SNT) ? SNT : cnt_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_entry_array.sv
// rtl/bp_entry_array.sv - entry table: two async read ports, one write port, global valid clear
module bp_entry_array
  import bp_pkg::*;
#(
  parameter int   ENTRIES  = BP_ENTRIES,
  parameter cnt_t CNT_INIT = WNT,
  localparam int  IDX_W    = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] lookupIdx,
  output bp_entry_t        lookupEntry,
  input  logic [IDX_W-1:0] updIdx,
  output bp_entry_t        updEntry,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  bp_entry_t        wrEntry,
  input  logic             clearValid
);

  bp_entry_t table_q [ENTRIES];

  assign lookupEntry = table_q[lookupIdx];
  assign updEntry    = table_q[updIdx];

  // Clear wins over a write so a flush drops the concurrent update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid  <= 1'b0;
        table_q[i].tag    <= '0;
        table_q[i].target <= '0;
        table_q[i].cnt    <= CNT_INIT;
      end
    end else if (clearValid) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i].valid <= 1'b0;
    end else if (wrEn) begin
      table_q[wrIdx] <= wrEntry;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters; BP_STATS_EN adds update/mispredict counters
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         PC_W     = BP_PC_W,
  parameter int         ENTRIES  = BP_ENTRIES,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_uncond,
  input  logic [PC_W-1:0] upd_target,
  input  logic            flush_all
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     upd_count,
  output logic [31:0]     mispredict_count
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] lookupIdx, updIdx;
  bp_entry_t        lookupEntry, updEntry, wrEntry;
  logic             lookupHit, updHit, updPredTaken, wrEn, updAccepted;
  logic             unusedLowBits;

  assign lookupIdx     = lookup_pc[IDX_W+1:2];
  assign updIdx        = upd_pc[IDX_W+1:2];
  assign unusedLowBits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lookupHit   = lookupEntry.valid && (lookupEntry.tag == lookup_pc[PC_W-1:IDX_W+2]);
  assign pred_taken  = lookupHit && lookupEntry.cnt[1];
  assign pred_target = pred_taken ? lookupEntry.target : lookup_pc + PC_W'(4);

  assign updHit       = updEntry.valid && (updEntry.tag == upd_pc[PC_W-1:IDX_W+2]);
  assign updPredTaken = updHit && updEntry.cnt[1];
  assign updAccepted  = upd_valid && !flush_all;

  always_comb begin
    wrEn    = 1'b0;
    wrEntry = updEntry;
    if (updAccepted) begin
      if (updHit) begin
        wrEn = 1'b1;
        if (upd_uncond) begin
          wrEntry.cnt    = ST;
          wrEntry.target = upd_target;
        end else begin
          wrEntry.cnt = sat_next(updEntry.cnt, upd_taken);
          if (upd_taken) wrEntry.target = upd_target;
        end
      end else if (upd_taken) begin
        // Allocation simply replaces whatever lives at this index.
        wrEn           = 1'b1;
        wrEntry.valid  = 1'b1;
        wrEntry.tag    = upd_pc[PC_W-1:IDX_W+2];
        wrEntry.target = upd_target;
        wrEntry.cnt    = upd_uncond ? ST : WT;
      end
    end
  end

  bp_entry_array #(
    .ENTRIES (ENTRIES),
    .CNT_INIT(cnt_t'(CNT_INIT))
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .lookupIdx  (lookupIdx),
    .lookupEntry(lookupEntry),
    .updIdx     (updIdx),
    .updEntry   (updEntry),
    .wrEn       (wrEn),
    .wrIdx      (updIdx),
    .wrEntry    (wrEntry),
    .clearValid (flush_all)
  );

`ifdef BP_STATS_EN
  logic mispredict;

  assign mispredict = (updPredTaken != upd_taken) ||
                      (updPredTaken && upd_taken && (updEntry.target != upd_target));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_count        <= '0;
      mispredict_count <= '0;
    end else if (updAccepted) begin
      if (upd_count != 32'hFFFF_FFFF) upd_count <= upd_count + 32'd1;
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed plus randomized checks against a table-level reference model
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] lookup_pc, upd_pc, upd_target, pred_target;
  logic        pred_taken, upd_valid, upd_taken, upd_uncond, flush_all;
`ifdef BP_STATS_EN
  logic [31:0] upd_count, mispredict_count;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference table: one slot per index, counters as plain integers 0..3.
  bit          mValid [16];
  logic [63:0] mTag   [16];
  logic [63:0] mTarget[16];
  int          mCnt   [16];
  int unsigned mUpd, mMis;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk        (clk),
    .reset      (reset),
    .lookup_pc  (lookup_pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_uncond (upd_uncond),
    .upd_target (upd_target),
    .flush_all  (flush_all)
`ifdef BP_STATS_EN
    ,
    .upd_count       (upd_count),
    .mispredict_count(mispredict_count)
`endif
  );

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 0; mTag[i] = 0; mTarget[i] = 0; mCnt[i] = 1;
    end
    mUpd = 0; mMis = 0;
  endtask

  task automatic model_predict(input logic [63:0] pc, output logic taken, output logic [63:0] tgt);
    int idx;
    idx   = int'((pc >> 2) % 16);
    taken = mValid[idx] && (mTag[idx] == (pc >> 6)) && (mCnt[idx] >= 2);
    tgt   = taken ? mTarget[idx] : pc + 64'd4;
  endtask

  task automatic model_update(input logic uv, input logic [63:0] pc, input logic t, input logic u,
                              input logic [63:0] tgt, input logic fl);
    int idx;
    logic hit, pt;
    logic [63:0] ptg;
    if (fl) begin
      for (int i = 0; i < 16; i++) mValid[i] = 0;
      return;
    end
    if (!uv) return;
    idx = int'((pc >> 2) % 16);
    hit = mValid[idx] && (mTag[idx] == (pc >> 6));
    model_predict(pc, pt, ptg);
    mUpd++;
    if ((pt != t) || (pt && t && mTarget[idx] != tgt)) mMis++;
    if (hit) begin
      if (u) begin
        mCnt[idx] = 3; mTarget[idx] = tgt;
      end else begin
        mCnt[idx] = t ? ((mCnt[idx] == 3) ? 3 : mCnt[idx] + 1) : ((mCnt[idx] == 0) ? 0 : mCnt[idx] - 1);
        if (t) mTarget[idx] = tgt;
      end
    end else if (t) begin
      mValid[idx] = 1; mTag[idx] = pc >> 6; mTarget[idx] = tgt; mCnt[idx] = u ? 3 : 2;
    end
  endtask

  task automatic check_model(input string tag);
    logic expT;
    logic [63:0] expG;
    model_predict(lookup_pc, expT, expG);
    nCompared++;
    assert (pred_taken === expT && pred_target === expG) else begin
      nMismatched++;
      $error("FAIL %s: observed taken=%0b target=%h expected taken=%0b target=%h",
             tag, pred_taken, pred_target, expT, expG);
    end
  endtask

  task automatic check_const(input string tag, input logic expT, input logic [63:0] expG);
    nCompared++;
    assert (pred_taken === expT && pred_target === expG) else begin
      nMismatched++;
      $error("FAIL %s: observed taken=%0b target=%h required taken=%0b target=%h",
             tag, pred_taken, pred_target, expT, expG);
    end
  endtask

`ifdef BP_STATS_EN
  task automatic check_stats(input string tag);
    nCompared++;
    assert (upd_count === 32'(mUpd) && mispredict_count === 32'(mMis)) else begin
      nMismatched++;
      $error("FAIL %s: observed upd=%0d mis=%0d expected upd=%0d mis=%0d",
             tag, upd_count, mispredict_count, mUpd, mMis);
    end
  endtask
`endif

  // One clock: drive, check at the falling edge, then advance the model across the rising edge.
  task automatic cyc(input string tag, input logic [63:0] lpc, input logic uv, input logic [63:0] upc,
                     input logic t, input logic u, input logic [63:0] tgt, input logic fl,
                     input bit useConst, input logic expT, input logic [63:0] expG);
    lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = t;
    upd_uncond = u; upd_target = tgt; flush_all = fl;
    @(negedge clk);
    check_model(tag);
    if (useConst) check_const({tag, "_k"}, expT, expG);
    @(posedge clk);
    model_update(uv, upc, t, u, tgt, fl);
    #1;
  endtask

  function automatic logic [63:0] rand_pc();
    return (64'($urandom_range(0, 3)) << 6) | (64'($urandom_range(0, 15)) << 2) | 64'($urandom_range(0, 3));
  endfunction

  initial begin
    reset = 1'b1; lookup_pc = 64'h100; upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_uncond = 0; upd_target = 0; flush_all = 0;
    model_reset();
    @(negedge clk);
    check_const("reset", 1'b0, 64'h104);
    @(posedge clk); #1;
    reset = 1'b0;

    cyc("upd100",    64'h100, 1, 64'h100, 1, 0, 64'h200, 0, 1, 1'b0, 64'h104);
    cyc("hit100",    64'h100, 1, 64'h100, 0, 0, 64'h200, 0, 1, 1'b1, 64'h200);
    cyc("wnt100",    64'h100, 0, 64'h0,   0, 0, 64'h0,   0, 1, 1'b0, 64'h104);
    cyc("sameOld",   64'h100, 1, 64'h100, 1, 0, 64'h200, 0, 1, 1'b0, 64'h104);
    cyc("sameNew",   64'h100, 0, 64'h0,   0, 0, 64'h0,   0, 1, 1'b1, 64'h200);
    cyc("alloc140",  64'h140, 1, 64'h140, 1, 0, 64'h300, 0, 1, 1'b0, 64'h144);
    cyc("alias100",  64'h100, 0, 64'h0,   0, 0, 64'h0,   0, 1, 1'b0, 64'h104);
    cyc("hit140",    64'h140, 0, 64'h0,   0, 0, 64'h0,   0, 1, 1'b1, 64'h300);
    cyc("flush",     64'h140, 1, 64'h180, 1, 0, 64'h400, 1, 1, 1'b1, 64'h300);
    cyc("flushed",   64'h140, 0, 64'h0,   0, 0, 64'h0,   0, 1, 1'b0, 64'h144);
    cyc("no180",     64'h180, 0, 64'h0,   0, 0, 64'h0,   0, 1, 1'b0, 64'h184);
    cyc("uncAlloc",  64'h208, 1, 64'h208, 1, 1, 64'h500, 0, 1, 1'b0, 64'h20c);
    cyc("unc3",      64'h208, 1, 64'h208, 0, 0, 64'h0,   0, 1, 1'b1, 64'h500);
    cyc("unc2",      64'h208, 1, 64'h208, 0, 0, 64'h0,   0, 1, 1'b1, 64'h500);
    cyc("unc1",      64'h208, 0, 64'h0,   0, 0, 64'h0,   0, 1, 1'b0, 64'h20c);
    cyc("wrap",      64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h0, 0, 0, 64'h0, 0, 1, 1'b0, 64'h2);
    cyc("alloc300",  64'h300, 1, 64'h300, 1, 0, 64'h600, 0, 1, 1'b0, 64'h304);
    cyc("hit300",    64'h300, 0, 64'h0,   0, 0, 64'h0,   0, 1, 1'b1, 64'h600);

    // Reset lands between edges with an update pending; that update must be lost.
    lookup_pc = 64'h300; upd_valid = 1; upd_pc = 64'h340; upd_taken = 1; upd_target = 64'h700;
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_const("midReset", 1'b0, 64'h304);
    @(posedge clk); #1;
    reset = 1'b0; upd_valid = 0;
    cyc("postReset", 64'h340, 0, 64'h0, 0, 0, 64'h0, 0, 1, 1'b0, 64'h344);
`ifdef BP_STATS_EN
    check_stats("statsReset");
`endif

    cyc("st1", 64'h100, 1, 64'h100, 1, 0, 64'h200, 0, 0, 1'b0, 64'h0);
    cyc("st2", 64'h100, 1, 64'h100, 1, 0, 64'h200, 0, 0, 1'b0, 64'h0);
    cyc("st3", 64'h100, 1, 64'h100, 0, 0, 64'h200, 0, 0, 1'b0, 64'h0);
    cyc("st4", 64'h100, 1, 64'h100, 1, 0, 64'h200, 0, 0, 1'b0, 64'h0);
`ifdef BP_STATS_EN
    check_stats("stats4");
`endif

    for (int i = 0; i < 400; i++) begin
      logic [63:0] tg;
      tg = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) tg = 64'h1000 + 64'($urandom_range(0, 3)) * 64'h40;
      cyc("rand", rand_pc(), ($urandom_range(0, 9) < 7), rand_pc(), 1'($urandom),
          ($urandom_range(0, 7) == 0), tg, ($urandom_range(0, 39) == 0), 0, 1'b0, 64'h0);
    end
`ifdef BP_STATS_EN
    check_stats("statsRand");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
